// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_READ_WAIT   = 3'd1,
    ST_WRITE_SETUP = 3'd2,
    ST_WRITE_WAIT  = 3'd3,
    ST_RELEASE     = 3'd4
  } arb_state_e;

  localparam logic [1:0] WM_NONE = 2'b00;
  localparam logic [1:0] WM_BYTE = 2'b01;
  localparam logic [1:0] WM_HALF = 2'b10;
  localparam logic [1:0] WM_WORD = 2'b11;

  function automatic logic is_write_mode(input logic [1:0] wm);
    return (wm != WM_NONE);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a sole requester wins, a tie goes to the side
// that did not win last time.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-addressable memory port between m0 (core) and m1 (debug),
// sequencing fixed-latency reads and done/error-terminated writes.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [1:0]        m0_write_mode,
  input  logic [1:0]        m1_write_mode,
  input  logic [31:0]       m0_wdata,
  input  logic [31:0]       m1_wdata,
  output logic              m0_ack,
  output logic              m1_ack,
  output logic              m0_err,
  output logic              m1_err,
  output logic [31:0]       m0_rdata_word,
  output logic [31:0]       m1_rdata_word,
  output logic [15:0]       m0_rdata_half,
  output logic [15:0]       m1_rdata_half,
  output logic [7:0]        m0_rdata_byte,
  output logic [7:0]        m1_rdata_byte,
  output logic [ADDR_W-1:0] mem_address,
  output logic [1:0]        mem_write_mode,
  output logic [7:0]        mem_write_byte,
  output logic [15:0]       mem_write_half_word,
  output logic [31:0]       mem_write_word,
  input  logic              mem_done,
  input  logic              mem_error,
  input  logic [7:0]        mem_byte_output,
  input  logic [15:0]       mem_half_word_output,
  input  logic [31:0]       mem_word_output
);

  localparam int CNT_MAX = (READ_LATENCY > WRITE_TIMEOUT) ? READ_LATENCY : WRITE_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  arb_state_e         state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_flag_q, err_flag_d;
  logic [ADDR_W-1:0]  mem_address_q, mem_address_d;
  logic [1:0]         mem_write_mode_q, mem_write_mode_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [1:0][31:0]   rdata_word_q, rdata_word_d;
  logic [1:0][15:0]   rdata_half_q, rdata_half_d;
  logic [1:0][7:0]    rdata_byte_q, rdata_byte_d;
  logic [1:0]         ack_q, ack_d;
  logic [1:0]         err_pulse_q, err_pulse_d;

  logic               grant_valid;
  logic               grant_id;
  logic [ADDR_W-1:0]  sel_addr;
  logic [1:0]         sel_wm;
  logic [31:0]        sel_wdata;

  rr_pick2 u_pick (
    .req0        (m0_req),
    .req1        (m1_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    if (grant_id) begin
      sel_addr  = m1_addr;
      sel_wm    = m1_write_mode;
      sel_wdata = m1_wdata;
    end else begin
      sel_addr  = m0_addr;
      sel_wm    = m0_write_mode;
      sel_wdata = m0_wdata;
    end
  end

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    last_grant_d     = last_grant_q;
    cnt_d            = cnt_q;
    err_flag_d       = err_flag_q;
    mem_address_d    = mem_address_q;
    mem_write_mode_d = mem_write_mode_q;
    wdata_d          = wdata_q;
    rdata_word_d     = rdata_word_q;
    rdata_half_d     = rdata_half_q;
    rdata_byte_d     = rdata_byte_q;
    ack_d            = 2'b00;
    err_pulse_d      = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          owner_d       = grant_id;
          last_grant_d  = grant_id;
          cnt_d         = '0;
          err_flag_d    = 1'b0;
          mem_address_d = sel_addr;
          wdata_d       = sel_wdata;
          if (is_write_mode(sel_wm)) begin
            state_d          = ST_WRITE_SETUP;
            mem_write_mode_d = sel_wm;
          end else begin
            state_d          = ST_READ_WAIT;
            mem_write_mode_d = WM_NONE;
          end
        end else begin
          mem_write_mode_d = WM_NONE;
        end
      end

      // Memory output is valid on the last counted cycle; capture it there.
      ST_READ_WAIT: begin
        if (cnt_q == CNT_W'(READ_LATENCY - 1)) begin
          rdata_word_d[owner_q] = mem_word_output;
          rdata_half_d[owner_q] = mem_half_word_output;
          rdata_byte_d[owner_q] = mem_byte_output;
          ack_d[owner_q]        = 1'b1;
          cnt_d                 = '0;
          state_d               = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WRITE_SETUP: begin
        cnt_d   = '0;
        state_d = ST_WRITE_WAIT;
      end

      // Error wins over done; the strobe is dropped as we leave.
      ST_WRITE_WAIT: begin
        if (mem_error) begin
          err_flag_d       = 1'b1;
          mem_write_mode_d = WM_NONE;
          state_d          = ST_RELEASE;
        end else if (mem_done) begin
          mem_write_mode_d = WM_NONE;
          state_d          = ST_RELEASE;
        end else if (cnt_q == CNT_W'(WRITE_TIMEOUT - 1)) begin
          err_flag_d       = 1'b1;
          mem_write_mode_d = WM_NONE;
          state_d          = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        mem_write_mode_d     = WM_NONE;
        ack_d[owner_q]       = 1'b1;
        err_pulse_d[owner_q] = err_flag_q;
        err_flag_d           = 1'b0;
        cnt_d                = '0;
        state_d              = ST_IDLE;
      end

      default: begin
        mem_write_mode_d = WM_NONE;
        err_flag_d       = 1'b0;
        cnt_d            = '0;
        state_d          = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      owner_q          <= 1'b0;
      last_grant_q     <= 1'b1;
      cnt_q            <= '0;
      err_flag_q       <= 1'b0;
      mem_address_q    <= '0;
      mem_write_mode_q <= WM_NONE;
      wdata_q          <= 32'h0000_0000;
      rdata_word_q     <= '0;
      rdata_half_q     <= '0;
      rdata_byte_q     <= '0;
      ack_q            <= 2'b00;
      err_pulse_q      <= 2'b00;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      last_grant_q     <= last_grant_d;
      cnt_q            <= cnt_d;
      err_flag_q       <= err_flag_d;
      mem_address_q    <= mem_address_d;
      mem_write_mode_q <= mem_write_mode_d;
      wdata_q          <= wdata_d;
      rdata_word_q     <= rdata_word_d;
      rdata_half_q     <= rdata_half_d;
      rdata_byte_q     <= rdata_byte_d;
      ack_q            <= ack_d;
      err_pulse_q      <= err_pulse_d;
    end
  end

  assign m0_ack              = ack_q[0];
  assign m1_ack              = ack_q[1];
  assign m0_err              = err_pulse_q[0];
  assign m1_err              = err_pulse_q[1];
  assign m0_rdata_word       = rdata_word_q[0];
  assign m1_rdata_word       = rdata_word_q[1];
  assign m0_rdata_half       = rdata_half_q[0];
  assign m1_rdata_half       = rdata_half_q[1];
  assign m0_rdata_byte       = rdata_byte_q[0];
  assign m1_rdata_byte       = rdata_byte_q[1];
  assign mem_address         = mem_address_q;
  assign mem_write_mode      = mem_write_mode_q;
  assign mem_write_byte      = wdata_q[7:0];
  assign mem_write_half_word = wdata_q[15:0];
  assign mem_write_word      = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expected responses,
// a negedge monitor pops and compares them against a small memory model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int RL = 2;
  localparam int WT = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [1:0][31:0] addr;
  logic [1:0][1:0]  wm;
  logic [1:0][31:0] wdata;
  logic [1:0]       ack, err;
  logic [1:0][31:0] rword;
  logic [1:0][15:0] rhalf;
  logic [1:0][7:0]  rbyte;
  logic [31:0]      mem_address;
  logic [1:0]       mem_write_mode;
  logic [7:0]       mem_write_byte;
  logic [15:0]      mem_write_half_word;
  logic [31:0]      mem_write_word;
  logic             mem_done, mem_error;
  logic [7:0]       mem_byte_output;
  logic [15:0]      mem_half_word_output;
  logic [31:0]      mem_word_output;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .READ_LATENCY(RL), .WRITE_TIMEOUT(WT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m1_req(req[1]),
    .m0_addr(addr[0]), .m1_addr(addr[1]),
    .m0_write_mode(wm[0]), .m1_write_mode(wm[1]),
    .m0_wdata(wdata[0]), .m1_wdata(wdata[1]),
    .m0_ack(ack[0]), .m1_ack(ack[1]),
    .m0_err(err[0]), .m1_err(err[1]),
    .m0_rdata_word(rword[0]), .m1_rdata_word(rword[1]),
    .m0_rdata_half(rhalf[0]), .m1_rdata_half(rhalf[1]),
    .m0_rdata_byte(rbyte[0]), .m1_rdata_byte(rbyte[1]),
    .mem_address(mem_address), .mem_write_mode(mem_write_mode),
    .mem_write_byte(mem_write_byte), .mem_write_half_word(mem_write_half_word),
    .mem_write_word(mem_write_word),
    .mem_done(mem_done), .mem_error(mem_error),
    .mem_byte_output(mem_byte_output), .mem_half_word_output(mem_half_word_output),
    .mem_word_output(mem_word_output)
  );

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] mword(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic [15:0] mhalf(input logic [31:0] a);
    if (a == 32'h0000_0100) return 16'hBEEF;
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction
  function automatic logic [7:0] mbyte(input logic [31:0] a);
    if (a == 32'h0000_0100) return 8'hEF;
    return a[7:0] + a[15:8] + 8'h3C;
  endfunction
  // Write response kind from addr[3:2]: 0 done, 1 error, 2 both, 3 never.
  function automatic int resp_kind(input logic [31:0] a);
    return int'(a[3:2]);
  endfunction
  function automatic int resp_delay(input logic [31:0] a);
    return 2 + (int'(a[6:4]) % 6);
  endfunction

  logic [31:0] addr_pipe = 32'h0;
  logic [3:0]  wcnt = 4'd0;

  always @(posedge clk) begin
    addr_pipe <= mem_address;
    if (mem_write_mode != 2'b00) wcnt <= wcnt + 4'd1;
    else wcnt <= 4'd0;
  end

  assign mem_word_output      = mword(addr_pipe);
  assign mem_half_word_output = mhalf(addr_pipe);
  assign mem_byte_output      = mbyte(addr_pipe);

  always_comb begin
    mem_done  = 1'b0;
    mem_error = 1'b0;
    if (mem_write_mode != 2'b00 && int'(wcnt) == resp_delay(mem_address) - 1) begin
      case (resp_kind(mem_address))
        0: mem_done = 1'b1;
        1: mem_error = 1'b1;
        2: begin mem_done = 1'b1; mem_error = 1'b1; end
        default: ;
      endcase
    end
  end

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [1:0]  wm;
    logic [31:0] wd;
    bit          err;
    int          mode_cycles;
  } txn_t;

  txn_t expq0[$];
  txn_t expq1[$];
  logic [31:0] mdl_word[2];
  logic [15:0] mdl_half[2];
  logic [7:0]  mdl_byte[2];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          mcyc = 0;
  logic [31:0] rec_addr, rec_word;
  logic [15:0] rec_half;
  logic [7:0]  rec_byte;
  logic [1:0]  rec_wm;
  int          log_id[$];
  int          log_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    expq0.delete();
    expq1.delete();
    for (int i = 0; i < 2; i++) begin
      mdl_word[i] = 32'h0;
      mdl_half[i] = 16'h0;
      mdl_byte[i] = 8'h0;
    end
    mcyc = 0;
  endtask

  task automatic issue(input int id, input logic [31:0] a, input logic [1:0] m, input logic [31:0] d);
    txn_t t;
    t.wr  = (m != WM_NONE);
    t.a   = a;
    t.wm  = m;
    t.wd  = d;
    t.err = t.wr && (resp_kind(a) != 0);
    t.mode_cycles = !t.wr ? 0 : (resp_kind(a) == 3 ? 1 + WT : resp_delay(a));
    if (id == 0) expq0.push_back(t);
    else expq1.push_back(t);
    addr[id]  = a;
    wm[id]    = m;
    wdata[id] = d;
    req[id]   = 1'b1;
  endtask

  task automatic wait_ack(input int id, output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (ack[id]) break;
      if (lat > 200) begin
        check($sformatf("ack_timeout_m%0d", id), 64'(lat), 64'd0);
        if (id == 0 && expq0.size() > 0) void'(expq0.pop_back());
        if (id == 1 && expq1.size() > 0) void'(expq1.pop_back());
        break;
      end
    end
    req[id] = 1'b0;
  endtask

  task automatic do_req(input int id, input logic [31:0] a, input logic [1:0] m,
                        input logic [31:0] d, output int lat);
    issue(id, a, m, d);
    wait_ack(id, lat);
  endtask

  // Monitor: pops the owner's expectation on every ack and checks invariants.
  initial begin
    txn_t t;
    bit   have;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (mem_write_mode != 2'b00) begin
          mcyc++;
          rec_addr = mem_address;
          rec_wm   = mem_write_mode;
          rec_word = mem_write_word;
          rec_half = mem_write_half_word;
          rec_byte = mem_write_byte;
        end
        if (ack == 2'b11) check("dual_ack", 64'(ack), 64'b01);
        for (int id = 0; id < 2; id++) begin
          if (err[id] && !ack[id]) check($sformatf("err_without_ack_m%0d", id), 64'(err[id]), 64'd0);
          if (ack[id]) begin
            have = 1'b0;
            if (id == 0 && expq0.size() > 0) begin t = expq0.pop_front(); have = 1'b1; end
            if (id == 1 && expq1.size() > 0) begin t = expq1.pop_front(); have = 1'b1; end
            log_id.push_back(id);
            log_cyc.push_back(cyc);
            if (!have) begin
              check($sformatf("unexpected_ack_m%0d", id), 64'(ack[id]), 64'd0);
            end else begin
              check($sformatf("err_m%0d", id), 64'(err[id]), 64'(t.err));
              check($sformatf("mode_cycles_m%0d", id), 64'(mcyc), 64'(t.mode_cycles));
              if (!t.wr) begin
                mdl_word[id] = mword(t.a);
                mdl_half[id] = mhalf(t.a);
                mdl_byte[id] = mbyte(t.a);
              end else begin
                check($sformatf("wr_addr_m%0d", id), 64'(rec_addr), 64'(t.a));
                check($sformatf("wr_mode_m%0d", id), 64'(rec_wm), 64'(t.wm));
                check($sformatf("wr_data_m%0d", id), {rec_word, rec_half, rec_byte, 8'h00},
                      {t.wd, t.wd[15:0], t.wd[7:0], 8'h00});
              end
            end
            mcyc = 0;
          end
        end
        for (int id = 0; id < 2; id++) begin
          check($sformatf("rdata_m%0d", id), {rword[id], rhalf[id], rbyte[id], 8'h00},
                {mdl_word[id], mdl_half[id], mdl_byte[id], 8'h00});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst   = 1'b0;
    req   = 2'b00;
    addr  = '0;
    wm    = '0;
    wdata = '0;
    model_clear();

    // Reset held with m0 requesting: nothing moves until release.
    issue(0, 32'h0000_0100, WM_NONE, 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("rst_ctrl", {ack, err, mem_write_mode, mem_address}, 64'd0);
      check("rst_rdata", {rword[0] | rword[1], rhalf[0] | rhalf[1], rbyte[0] | rbyte[1]}, 64'd0);
    end
    rst = 1'b1;
    wait_ack(0, lat);
    check("rst_grant_lat", 64'(lat), 64'd3);

    @(negedge clk);
    do_req(0, 32'h0000_0200, WM_NONE, 32'h0, lat);
    check("read_lat", 64'(lat), 64'd3);

    @(negedge clk);
    do_req(1, 32'h0000_0040, WM_WORD, 32'h1234_5678, lat);
    check("write_done_lat", 64'(lat), 64'd8);

    @(negedge clk);
    do_req(0, 32'h0000_0008, WM_BYTE, 32'h0000_00A5, lat);
    check("write_err_done_lat", 64'(lat), 64'd4);

    @(negedge clk);
    do_req(1, 32'h0000_000C, WM_HALF, 32'hBEEF_1234, lat);
    check("write_timeout_lat", 64'(lat), 64'(3 + WT));

    // Asynchronous reset while the write is waiting for the memory.
    @(negedge clk);
    issue(0, 32'h0000_001C, WM_WORD, 32'hCAFE_F00D);
    repeat (5) @(posedge clk);
    check("midwrite_mode_before", 64'(mem_write_mode), 64'(WM_WORD));
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    check("midwrite_async_mode", 64'(mem_write_mode), 64'd0);
    check("midwrite_async_ack", {ack, err, mem_address}, 64'd0);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("midwrite_no_ack", 64'(ack), 64'd0);
    rst = 1'b1;

    // Continuous contention right after reset: m0 first, then alternating.
    @(negedge clk);
    log_id.delete();
    log_cyc.delete();
    fork
      begin
        int l0;
        for (int i = 0; i < 4; i++) do_req(0, 32'h0000_0300 + 32'(i * 4), WM_NONE, 32'h0, l0);
      end
      begin
        int l1;
        for (int i = 0; i < 4; i++) do_req(1, 32'h0000_0500 + 32'(i * 8), WM_NONE, 32'h0, l1);
      end
    join
    check("cont_count", 64'(log_id.size()), 64'd8);
    for (int i = 0; i < log_id.size(); i++) begin
      check("cont_order", 64'(log_id[i]), 64'(i % 2));
      if (i > 0) check("cont_spacing", 64'(log_cyc[i] - log_cyc[i-1]), 64'd3);
    end

    // Randomized traffic from both requesters.
    fork
      begin
        int l0;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          do_req(0, $urandom, 2'($urandom_range(0, 3)), $urandom, l0);
        end
      end
      begin
        int l1;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          do_req(1, $urandom, 2'($urandom_range(0, 3)), $urandom, l1);
        end
      end
    join

    repeat (4) @(negedge clk);
    check("q0_drained", 64'(expq0.size()), 64'd0);
    check("q1_drained", 64'(expq1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
